// File: rtl/uart_rx_core_pkg.sv
// Shared UART receive definitions: register map, STATUS bit positions, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_rx_core_pkg;

    localparam logic [7:0] UART_REG_STATUS = 8'h04;
    localparam logic [7:0] UART_REG_RXDATA = 8'h0C;

    localparam int STATUS_TX_BUSY   = 0;
    localparam int STATUS_RX_VALID  = 1;
    localparam int STATUS_FRAME_ERR = 2;
    localparam int STATUS_OVERRUN   = 3;

    // Shortest bit period that still leaves a usable mid-bit sample point.
    localparam int MIN_BAUD = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_core_if.sv
// Register-side bundle between uart_ctrl (master) and the receiver core (slave).
// Latency: wires only.
// Backpressure: none; rx_pop/err_clr are single-cycle pulses from the master.
interface uart_rx_core_if #(
    parameter int FIFO_DEPTH = 4,
    parameter int BAUD_W     = 16
);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    logic [BAUD_W-1:0] baud_div;
    logic              rx_en;
    logic              rx_pop;
    logic              err_clr;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [LVL_W-1:0]  rx_level;
    logic              rx_busy;
    logic              frame_err;
    logic              overrun;

    modport master (
        output baud_div, rx_en, rx_pop, err_clr,
        input  rx_data, rx_valid, rx_level, rx_busy, frame_err, overrun
    );

    modport slave (
        input  baud_div, rx_en, rx_pop, err_clr,
        output rx_data, rx_valid, rx_level, rx_busy, frame_err, overrun
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO holding received bytes; head is presented combinationally.
// Latency: a pushed entry is visible at the head the cycle after the push edge.
// Backpressure: push_rdy low when full unless a pop frees a slot in the same cycle.
module uart_rx_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    output logic             push_rdy,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty    = (level == '0);
        full     = (level == LVL_W'(DEPTH));
        do_pop   = pop && !empty;
        push_rdy = !full || do_pop;
        do_push  = push && push_rdy;
        head_dat = empty ? '0 : mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: synchronise, mid-bit sample, deserialise LSB-first, buffer in FIFO.
// Latency: byte visible one cycle after the mid-stop-bit sample (~2-3 + bd/2 + 9*bd clk).
// Backpressure: none on the line; a byte completing into a full FIFO is dropped and flagged.
module uart_rx_core
    import uart_rx_core_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int BAUD_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              uart_rx,
    uart_rx_core_if.slave     bus
);

    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    logic              rx_meta;
    logic              rx_sync;
    logic              rx_prev;
    uart_rx_state_e    state;
    logic [BAUD_W-1:0] bd;
    logic [BAUD_W-1:0] cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;

    logic [BAUD_W-1:0] bd_eff;
    logic [BAUD_W-1:0] half_m1;
    logic [BAUD_W-1:0] bd_m1;
    logic              fall;
    logic              stop_hit;
    logic              push_vld;
    logic              push_rdy;
    logic              frame_set;
    logic              overrun_set;
    logic [LVL_W-1:0]  level;

    always_comb begin
        bd_eff      = (bus.baud_div < BAUD_W'(MIN_BAUD)) ? BAUD_W'(MIN_BAUD) : bus.baud_div;
        half_m1     = (bd >> 1) - BAUD_W'(1);
        bd_m1       = bd - BAUD_W'(1);
        fall        = rx_prev && !rx_sync;
        stop_hit    = (state == STOP) && bus.rx_en && (cnt == bd_m1);
        push_vld    = stop_hit && rx_sync;
        frame_set   = stop_hit && !rx_sync;
        overrun_set = push_vld && !push_rdy;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Leaving STOP at mid-stop-bit lets a start bit that follows with no gap be caught.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bd      <= BAUD_W'(MIN_BAUD);
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.rx_en && fall) begin
                        state   <= START;
                        bd      <= bd_eff;
                        cnt     <= '0;
                        bit_idx <= '0;
                    end
                end
                START: begin
                    if (!bus.rx_en) begin
                        state <= IDLE;
                    end else if (cnt == half_m1) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (!bus.rx_en) begin
                        state <= IDLE;
                    end else if (cnt == bd_m1) begin
                        cnt            <= '0;
                        shift[bit_idx] <= rx_sync;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (!bus.rx_en || (cnt == bd_m1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A fresh error in the clear cycle takes priority so it is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.frame_err <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            bus.frame_err <= frame_set   || (bus.frame_err && !bus.err_clr);
            bus.overrun   <= overrun_set || (bus.overrun   && !bus.err_clr);
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push_vld),
        .push_dat (shift),
        .push_rdy (push_rdy),
        .pop      (bus.rx_pop),
        .head_dat (bus.rx_data),
        .level    (level)
    );

    assign bus.rx_level = level;
    assign bus.rx_valid = (level != '0);
    assign bus.rx_busy  = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed tables, corner sequences, random frames vs a queue model.
module tb_uart_rx_core;

    localparam int DEPTH    = 4;
    localparam int BW       = 16;
    localparam int BIT_CLKS = 8;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic uart_rx = 1'b1;

    uart_rx_core_if #(.FIFO_DEPTH(DEPTH), .BAUD_W(BW)) bus ();

    uart_rx_core #(.FIFO_DEPTH(DEPTH), .BAUD_W(BW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .uart_rx (uart_rx),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO contents as a queue plus sticky flags.
    logic [7:0] mq[$];
    logic       m_ferr = 1'b0;
    logic       m_ovr  = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_level;
        logic       exp_ferr;
        logic       exp_ovr;
        logic [7:0] exp_head;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b);
        uart_rx = b;
        tick(BIT_CLKS);
    endtask

    // Full 8N1 frame; a low stop bit is followed by one idle bit so the next start edge exists.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
        uart_rx = 1'b1;
        if (!stop) drive_bit(1'b1);
        if (stop) begin
            if (mq.size() < DEPTH) mq.push_back(d);
            else m_ovr = 1'b1;
        end else begin
            m_ferr = 1'b1;
        end
    endtask

    task automatic pop();
        logic [7:0] tmp;
        bus.rx_pop = 1'b1;
        tick(1);
        bus.rx_pop = 1'b0;
        if (mq.size() > 0) tmp = mq.pop_front();
    endtask

    task automatic clr();
        bus.err_clr = 1'b1;
        tick(1);
        bus.err_clr = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_level"}, 32'(bus.rx_level), 32'(mq.size()));
        check({tag, "_valid"}, 32'(bus.rx_valid), 32'(mq.size() != 0));
        check({tag, "_data"},  32'(bus.rx_data),  (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
        check({tag, "_ferr"},  32'(bus.frame_err), 32'(m_ferr));
        check({tag, "_ovr"},   32'(bus.overrun),   32'(m_ovr));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},  32'(bus.rx_data),   32'd0);
        check({tag, "_valid"}, 32'(bus.rx_valid),  32'd0);
        check({tag, "_level"}, 32'(bus.rx_level),  32'd0);
        check({tag, "_busy"},  32'(bus.rx_busy),   32'd0);
        check({tag, "_ferr"},  32'(bus.frame_err), 32'd0);
        check({tag, "_ovr"},   32'(bus.overrun),   32'd0);
    endtask

    initial begin
        logic       saw_busy;
        logic [7:0] d;
        logic       stop;
        int         nfr;
        int         npop;

        vecs[0] = '{8'h11, 1'b1, 1, 1'b0, 1'b0, 8'h11};
        vecs[1] = '{8'h12, 1'b1, 2, 1'b0, 1'b0, 8'h11};
        vecs[2] = '{8'h13, 1'b1, 3, 1'b0, 1'b0, 8'h11};
        vecs[3] = '{8'h14, 1'b1, 4, 1'b0, 1'b0, 8'h11};
        vecs[4] = '{8'h15, 1'b1, 4, 1'b0, 1'b1, 8'h11};
        vecs[5] = '{8'h00, 1'b0, 4, 1'b1, 1'b1, 8'h11};

        bus.baud_div = 16'd8;
        bus.rx_en    = 1'b1;
        bus.rx_pop   = 1'b0;
        bus.err_clr  = 1'b0;
        tick(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        tick(3);

        // Single byte then pop
        send_frame(8'h55, 1'b1);
        tick(2);
        check("t1_valid", 32'(bus.rx_valid), 32'd1);
        check("t1_data",  32'(bus.rx_data),  32'h55);
        check("t1_level", 32'(bus.rx_level), 32'd1);
        check("t1_ferr",  32'(bus.frame_err), 32'd0);
        pop();
        check("t1_valid_after_pop", 32'(bus.rx_valid), 32'd0);
        check("t1_data_after_pop",  32'(bus.rx_data),  32'd0);

        // Back-to-back frames, no idle gap
        send_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b1);
        tick(2);
        check("t2_level", 32'(bus.rx_level), 32'd2);
        check("t2_data0", 32'(bus.rx_data),  32'hA5);
        pop();
        check("t2_data1", 32'(bus.rx_data),  32'h3C);
        pop();
        check("t2_empty", 32'(bus.rx_valid), 32'd0);

        // Framing error, clear, recovery
        send_frame(8'h00, 1'b0);
        check("t3_ferr",  32'(bus.frame_err), 32'd1);
        check("t3_level", 32'(bus.rx_level),  32'd0);
        clr();
        check("t3_ferr_clr", 32'(bus.frame_err), 32'd0);
        send_frame(8'h81, 1'b1);
        tick(2);
        check("t3_data",  32'(bus.rx_data),  32'h81);
        check("t3_level", 32'(bus.rx_level), 32'd1);
        pop();

        // Short low glitch is rejected as a false start
        uart_rx = 1'b0;
        tick(3);
        uart_rx = 1'b1;
        saw_busy = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus.rx_busy) saw_busy = 1'b1;
            tick(1);
        end
        check("t4_saw_busy", 32'(saw_busy), 32'd1);
        check("t4_busy",  32'(bus.rx_busy),   32'd0);
        check("t4_level", 32'(bus.rx_level),  32'd0);
        check("t4_ferr",  32'(bus.frame_err), 32'd0);
        check("t4_ovr",   32'(bus.overrun),   32'd0);

        // Table: fill past capacity without popping, then a framing error
        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].data, vecs[v].stop);
            tick(2);
            check($sformatf("tbl%0d_level", v), 32'(bus.rx_level),  32'(vecs[v].exp_level));
            check($sformatf("tbl%0d_ferr", v),  32'(bus.frame_err), 32'(vecs[v].exp_ferr));
            check($sformatf("tbl%0d_ovr", v),   32'(bus.overrun),   32'(vecs[v].exp_ovr));
            check($sformatf("tbl%0d_head", v),  32'(bus.rx_data),   32'(vecs[v].exp_head));
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t5_pop%0d", i), 32'(bus.rx_data), 32'(8'h11 + i));
            pop();
        end
        check("t5_empty", 32'(bus.rx_valid), 32'd0);
        clr();
        check("t5_ferr_clr", 32'(bus.frame_err), 32'd0);
        check("t5_ovr_clr",  32'(bus.overrun),   32'd0);

        // rx_en dropped at bit 4 aborts the frame, FIFO untouched
        send_frame(8'h77, 1'b1);
        tick(2);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d_c3(i));
        check("t6_busy_mid", 32'(bus.rx_busy), 32'd1);
        uart_rx    = d_c3(4);
        bus.rx_en  = 1'b0;
        tick(1);
        check("t6_busy_abort", 32'(bus.rx_busy), 32'd0);
        uart_rx   = 1'b1;
        bus.rx_en = 1'b1;
        tick(20);
        check("t6_level", 32'(bus.rx_level),  32'd1);
        check("t6_head",  32'(bus.rx_data),   32'h77);
        check("t6_ferr",  32'(bus.frame_err), 32'd0);
        send_frame(8'hC3, 1'b1);
        tick(2);
        check("t6_level2", 32'(bus.rx_level), 32'd2);
        pop();
        check("t6_c3", 32'(bus.rx_data), 32'hC3);
        pop();

        // Reset in the middle of a frame flushes everything
        send_frame(8'h5A, 1'b1);
        send_frame(8'hFF, 1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        check("t7_busy_mid", 32'(bus.rx_busy), 32'd1);
        rst_n = 1'b0;
        #2;
        check_all_zero("t7_rst");
        mq.delete();
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        uart_rx = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        send_frame(8'hC3, 1'b1);
        tick(2);
        check("t7_c3",    32'(bus.rx_data),  32'hC3);
        check("t7_level", 32'(bus.rx_level), 32'd1);
        pop();

        // Random frames, pops and clears against the queue model
        for (int it = 0; it < 25; it++) begin
            nfr = $urandom_range(1, 2);
            for (int f = 0; f < nfr; f++) begin
                d    = 8'($urandom);
                stop = ($urandom_range(0, 7) != 0);
                send_frame(d, stop);
            end
            tick(2);
            check_model($sformatf("rnd%0d_rx", it));
            npop = $urandom_range(0, 3);
            for (int p = 0; p < npop; p++) begin
                check($sformatf("rnd%0d_pop%0d", it, p), 32'(bus.rx_data),
                      (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
                pop();
            end
            if ($urandom_range(0, 3) == 0) clr();
            check_model($sformatf("rnd%0d_post", it));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    function automatic logic d_c3(input int i);
        logic [7:0] v;
        v = 8'hC3;
        return v[i];
    endfunction

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
8N1 UART receiver for the SoC UART peripheral; the receive-side counterpart of the uart_ctrl TX path.
- Samples the asynchronous uart_rx pin and deserialises frames LSB-first, sampling at mid-bit.
- Buffers received bytes in a small FIFO.
- uart_ctrl instantiates it: RXDATA reads return the FIFO head and pop it; STATUS exposes rx_valid, frame_err and overrun. It shares the CTRL baud_div with TX.

Parameters:
FIFO_DEPTH, 4, receive FIFO entries (power of two, >=2)
BAUD_W, 16, width of baud_div

Ports:
clk  in  1  system clock (100 MHz in sim)
rst_n  in  1  asynchronous active-low reset
uart_rx  in  1  asynchronous serial input, idle high
baud_div  in  BAUD_W  clocks per bit, from CTRL; values <4 treated as 4
rx_en  in  1  receiver enable
rx_pop  in  1  one-cycle pulse, consume FIFO head
err_clr  in  1  one-cycle pulse, clear sticky error flags
rx_data  out  8  FIFO head byte; 0 when empty
rx_valid  out  1  FIFO non-empty
rx_level  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy
rx_busy  out  1  receiver FSM not IDLE
frame_err  out  1  sticky: stop bit sampled low
overrun  out  1  sticky: completed byte dropped because FIFO full

Behaviour:
Reset and synchroniser
- Reset: all outputs 0, FIFO empty, FSM IDLE, synchroniser flops = 1.
- uart_rx passes through a 2-flop synchroniser; edge detect uses a third registered copy.

FSM states IDLE, START, DATA, STOP
- IDLE -> START on a synced falling edge with rx_en=1. baud_div is latched here (bd = max(baud_div,4)) and held for the whole frame; bit counter cleared.
- START: after floor(bd/2) clocks, sample the line.
  - 1 -> false start, back to IDLE.
  - 0 -> DATA, bit_idx=0, baud counter reset.
- DATA: every bd clocks, sample into shift[bit_idx], LSB first. After bit 7 -> STOP.
- STOP: after bd clocks, sample the line.
  - 1 -> push byte.
  - 0 -> set frame_err, discard byte.
  - Either way -> IDLE on that same edge (mid-stop-bit), so back-to-back frames with no idle gap are received.
- rx_en=0 in any non-IDLE state: abort to IDLE next cycle, discard the partial byte, keep FIFO contents.

Latency
- The pushed byte is visible on rx_data/rx_valid the cycle after the stop-bit sample edge.
- Stop-bit sample edge ≈ 2–3 clk (sync) + bd/2 + 9*bd after the line falls.

FIFO
- Push while full: byte dropped, overrun set.
- Push and pop in the same cycle when full: both happen, no overrun, level unchanged.
- Pop while empty: ignored.
- Push and pop in the same cycle when empty: push only.
- rx_level never exceeds FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.

Error flags
- err_clr clears frame_err and overrun. A new error in the same cycle as err_clr wins (flag stays 1).
- rx_busy = (state != IDLE).
- Reset asserted mid-frame: immediate return to reset values, FIFO flushed.

Decomposition:
snn_soc_pkg gains:
- UART_REG_RXDATA/STATUS offsets
- STATUS bit indices: TX_BUSY=0, RX_VALID=1, FRAME_ERR=2, OVERRUN=3
- enum typedef uart_rx_state_e {IDLE, START, DATA, STOP}

Sub-module uart_rx_fifo: synchronous FIFO with push/pop/level, parameterised depth, width 8. The FSM, synchroniser and error logic stay in uart_rx_core.

Test Plan:
All tests use baud_div=8 and a bench task that drives 8N1 frames on uart_rx at 8 clk/bit.
1. Drive 0x55 -> rx_valid=1, rx_data=0x55, rx_level=1, frame_err=0. Pulse rx_pop -> rx_valid=0, rx_data=0.
2. Drive 0xA5 then 0x3C back-to-back (next start bit immediately after stop bit) -> level=2, pops return 0xA5 then 0x3C.
3. Drive 0x00 with stop bit held low -> frame_err=1, level=0. Pulse err_clr -> frame_err=0. Next byte 0x81 is received correctly.
4. Low glitch of 3 clk on idle line -> rx_busy returns 0 before any data bit, level=0, no error flags.
5. Drive 0x11..0x15 without popping -> level=4, overrun=1. Pops return 0x11, 0x12, 0x13, 0x14, then rx_valid=0.
6. Mid-frame checks -> next frame 0xC3 is then received intact:
   - Deassert rx_en at bit 4 -> rx_busy=0 next cycle, FIFO unchanged.
   - Assert rst_n=0 mid-frame -> all outputs 0.
